hamming_secded_decoder: RTL and testbench

Single-error-correcting, double-error-detecting (SECDED) Hamming decoder with an integrated pad stage. It takes a received data word and its check bits, which arrive as separate fields (for example, unpacked from a deserializer shift register). It interleaves them into an extended-Hamming codeword, computes the syndrome, corrects single-bit errors and reports the error class and location. All outputs are registered, giving one cycle of latency.

---
 rtl/hamming_secded_decoder_if.sv | 33 +++
 rtl/hamming_secded_decoder.sv | 128 ++++++++++++
 tb/tb_hamming_secded_decoder.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/hamming_secded_decoder_if.sv
// Bus bundle for the SECDED decoder: received word in, decoded result out.
interface hamming_secded_decoder_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    // Smallest r with 2^r >= DATA_WIDTH + r + 1
    function automatic int unsigned calc_code_bits(int unsigned dw);
        int unsigned r = 1;
        while ((32'd1 << r) < dw + r + 1) r++;
        return r;
    endfunction

    localparam int unsigned CODE_BITS  = calc_code_bits(DATA_WIDTH);
    localparam int unsigned ADDR_WIDTH = CODE_BITS;

    logic                    valid_i;
    logic [DATA_WIDTH-1:0]   data_in_i;
    logic [CODE_BITS:0]      pad_bits_i;
    logic                    valid_o;
    logic [DATA_WIDTH-1:0]   data_out_o;
    logic [DATA_WIDTH-1:0]   raw_data_o;
    logic [ADDR_WIDTH-1:0]   fault_location_o;
    logic [1:0]              num_errors_o;

    modport master (
        output valid_i, data_in_i, pad_bits_i,
        input  valid_o, data_out_o, raw_data_o, fault_location_o, num_errors_o
    );

    modport slave (
        input  valid_i, data_in_i, pad_bits_i,
        output valid_o, data_out_o, raw_data_o, fault_location_o, num_errors_o
    );
endinterface

// File: rtl/hamming_secded_decoder.sv
// SECDED Hamming decoder: interleaves data and check bits into an extended
// Hamming codeword, corrects single errors, flags double/invalid errors.
// All outputs registered (one cycle latency).
module hamming_secded_decoder #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input logic                     clk_i,
    input logic                     rst_i,
    hamming_secded_decoder_if.slave bus
);
    function automatic int unsigned calc_code_bits(int unsigned dw);
        int unsigned r = 1;
        while ((32'd1 << r) < dw + r + 1) r++;
        return r;
    endfunction

    localparam int unsigned CODE_BITS   = calc_code_bits(DATA_WIDTH);
    localparam int unsigned CODED_WIDTH = DATA_WIDTH + CODE_BITS + 1;
    localparam int unsigned ADDR_WIDTH  = CODE_BITS;
    localparam logic [ADDR_WIDTH-1:0] MaxPos = ADDR_WIDTH'(CODED_WIDTH - 1);

    // Codeword position of payload bit idx: the idx-th non-power-of-two above 2
    function automatic int unsigned data_pos(int unsigned idx);
        int unsigned pos = 2;
        for (int unsigned n = 0; n <= idx; n++) begin
            pos++;
            while ((pos & (pos - 1)) == 0) pos++;
        end
        return pos;
    endfunction

    // Positions 1..CODED_WIDTH-1 whose index has bit k set
    function automatic logic [CODED_WIDTH-1:0] col_mask(int unsigned k);
        logic [CODED_WIDTH-1:0] m = '0;
        for (int unsigned i = 1; i < CODED_WIDTH; i++) begin
            if (((i >> k) & 1) != 0) m = m | (CODED_WIDTH'(1) << i);
        end
        return m;
    endfunction

    logic [CODED_WIDTH-1:0] code;
    logic [ADDR_WIDTH-1:0]  syndrome;
    logic                   parity;
    logic                   single_err;
    logic [1:0]             num_errors;
    logic [DATA_WIDTH-1:0]  data_corr;

    logic                   valid_q, valid_d;
    logic [DATA_WIDTH-1:0]  data_out_q, data_out_d;
    logic [DATA_WIDTH-1:0]  raw_data_q, raw_data_d;
    logic [ADDR_WIDTH-1:0]  fault_q, fault_d;
    logic [1:0]             num_errors_q, num_errors_d;

    // Pad stage: overall parity at 0, Hamming parities at powers of two, data elsewhere
    assign code[0] = bus.pad_bits_i[0];
    for (genvar k = 0; k < CODE_BITS; k++) begin : g_par_pos
        assign code[1 << k] = bus.pad_bits_i[k+1];
    end
    for (genvar j = 0; j < DATA_WIDTH; j++) begin : g_data_pos
        assign code[data_pos(j)] = bus.data_in_i[j];
    end

    // Syndrome bit k is the parity over positions with index bit k set
    for (genvar k = 0; k < ADDR_WIDTH; k++) begin : g_syn
        assign syndrome[k] = ^(code & col_mask(k));
    end
    assign parity = ^code;

    // Classify (syndrome, parity) into the error class
    always_comb begin
        single_err = 1'b0;
        num_errors = 2'd0;
        if (syndrome == '0 && !parity) begin
            num_errors = 2'd0;
        end else if (parity && syndrome <= MaxPos) begin
            num_errors = 2'd1;
            single_err = 1'b1;
        end else if (!parity) begin
            num_errors = 2'd2;
        end else begin
            num_errors = 2'd3;
        end
    end

    // Flip only the payload bit the syndrome points at; parity-bit errors leave data intact
    for (genvar j = 0; j < DATA_WIDTH; j++) begin : g_corr
        assign data_corr[j] = bus.data_in_i[j] ^
                              (single_err && (syndrome == ADDR_WIDTH'(data_pos(j))));
    end

    // Next state: load on valid, otherwise hold results and drop valid
    always_comb begin
        valid_d      = bus.valid_i;
        data_out_d   = data_out_q;
        raw_data_d   = raw_data_q;
        fault_d      = fault_q;
        num_errors_d = num_errors_q;
        if (bus.valid_i) begin
            data_out_d   = data_corr;
            raw_data_d   = bus.data_in_i;
            fault_d      = syndrome;
            num_errors_d = num_errors;
        end
    end

    // Output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q      <= 1'b0;
            data_out_q   <= '0;
            raw_data_q   <= '0;
            fault_q      <= '0;
            num_errors_q <= '0;
        end else begin
            valid_q      <= valid_d;
            data_out_q   <= data_out_d;
            raw_data_q   <= raw_data_d;
            fault_q      <= fault_d;
            num_errors_q <= num_errors_d;
        end
    end

    assign bus.valid_o          = valid_q;
    assign bus.data_out_o       = data_out_q;
    assign bus.raw_data_o       = raw_data_q;
    assign bus.fault_location_o = fault_q;
    assign bus.num_errors_o     = num_errors_q;
endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Scoreboard bench for hamming_secded_decoder (DATA_WIDTH=8).
module tb_hamming_secded_decoder;
    localparam int unsigned DW = 8;

    typedef struct {
        logic       v;
        logic [7:0] dout;
        logic [7:0] raw;
        logic [3:0] fault;
        logic [1:0] num;
    } exp_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    hamming_secded_decoder_if #(.DATA_WIDTH(DW)) bus ();

    hamming_secded_decoder #(.DATA_WIDTH(DW)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    exp_t exp_q[$];
    exp_t mdl = '{v: 1'b0, dout: 8'h0, raw: 8'h0, fault: 4'h0, num: 2'h0};
    int   checks_n = 0;
    int   fail_n   = 0;
    int   dpos[8]  = '{3, 5, 6, 7, 9, 10, 11, 12};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks_n++;
        if (got !== want) begin
            fail_n++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, want);
        end
    endtask

    function automatic logic bit_of(input logic [15:0] v, input int p);
        return |((v >> p) & 16'd1);
    endfunction

    function automatic logic [12:0] encode(input logic [7:0] d);
        logic [12:0] cw = '0;
        logic        par;
        for (int j = 0; j < 8; j++)
            if (bit_of(16'(d), j)) cw = cw | (13'd1 << dpos[j]);
        for (int k = 0; k < 4; k++) begin
            par = 1'b0;
            for (int i = 1; i < 13; i++)
                if (((i >> k) & 1) != 0 && bit_of(16'(cw), i)) par = ~par;
            if (par) cw = cw | (13'd1 << (1 << k));
        end
        if (^cw) cw = cw | 13'd1;
        return cw;
    endfunction

    function automatic logic [7:0] extract(input logic [12:0] cw);
        logic [7:0] d = '0;
        for (int j = 0; j < 8; j++)
            if (bit_of(16'(cw), dpos[j])) d = d | (8'd1 << j);
        return d;
    endfunction

    // Drive one cycle of stimulus and push the result it must produce
    task automatic drive(input logic r, input logic v, input logic [7:0] d, input logic [4:0] p,
                         input logic [7:0] edo, input logic [3:0] ef, input logic [1:0] en);
        @(negedge clk_i);
        rst_i          = r;
        bus.valid_i    = v;
        bus.data_in_i  = d;
        bus.pad_bits_i = p;
        if (r) mdl = '{v: 1'b0, dout: 8'h0, raw: 8'h0, fault: 4'h0, num: 2'h0};
        else if (v) mdl = '{v: 1'b1, dout: edo, raw: d, fault: ef, num: en};
        else mdl.v = 1'b0;
        exp_q.push_back(mdl);
    endtask

    // Encode d, apply an error mask, and derive the expectation from the mask itself
    task automatic send_err(input logic [7:0] d, input logic [12:0] mask);
        logic [12:0] rx;
        logic [3:0]  s = '0;
        int          nflip = 0;
        logic [1:0]  num;
        logic [7:0]  dexp;
        rx = encode(d) ^ mask;
        for (int i = 0; i < 13; i++)
            if (bit_of(16'(mask), i)) begin
                s = s ^ 4'(i);
                nflip++;
            end
        if (nflip == 0) num = 2'd0;
        else if ((nflip % 2) == 0) num = 2'd2;
        else if (s <= 4'd12) num = 2'd1;
        else num = 2'd3;
        dexp = (num == 2'd1) ? extract(rx ^ (13'd1 << s)) : extract(rx);
        drive(1'b0, 1'b1, extract(rx), {rx[8], rx[4], rx[2], rx[1], rx[0]}, dexp, s, num);
    endtask

    // Compare the DUT against the oldest pending expectation, 1 time unit after each edge
    always @(posedge clk_i) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("valid_o", 32'(bus.valid_o), 32'(e.v));
            check_eq("data_out_o", 32'(bus.data_out_o), 32'(e.dout));
            check_eq("raw_data_o", 32'(bus.raw_data_o), 32'(e.raw));
            check_eq("fault_location_o", 32'(bus.fault_location_o), 32'(e.fault));
            check_eq("num_errors_o", 32'(bus.num_errors_o), 32'(e.num));
        end
    end

    initial begin
        logic [12:0] mask;
        int          n;
        bus.valid_i    = 1'b0;
        bus.data_in_i  = '0;
        bus.pad_bits_i = '0;

        drive(1'b1, 1'b0, 8'h00, 5'h00, 8'h00, 4'd0, 2'd0);
        drive(1'b1, 1'b0, 8'h00, 5'h00, 8'h00, 4'd0, 2'd0);

        drive(1'b0, 1'b1, 8'hA5, 5'h06, 8'hA5, 4'd0, 2'd0);   // clean
        drive(1'b0, 1'b1, 8'hA4, 5'h06, 8'hA5, 4'd3, 2'd1);   // data bit error
        drive(1'b0, 1'b1, 8'hA5, 5'h04, 8'hA5, 4'd1, 2'd1);   // p0 error
        drive(1'b0, 1'b1, 8'hA5, 5'h07, 8'hA5, 4'd0, 2'd1);   // overall parity error
        drive(1'b0, 1'b1, 8'hA6, 5'h06, 8'hA6, 4'd6, 2'd2);   // double error
        drive(1'b0, 1'b1, 8'h25, 5'h05, 8'h25, 4'd13, 2'd3);  // invalid syndrome

        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) drive(1'b0, 1'b1, 8'hA5, 5'h06, 8'hA5, 4'd0, 2'd0);
            else            drive(1'b0, 1'b1, 8'hA4, 5'h06, 8'hA5, 4'd3, 2'd1);
        end

        drive(1'b0, 1'b0, 8'h3C, 5'h1F, 8'h00, 4'd0, 2'd0);   // idle: outputs hold
        drive(1'b0, 1'b0, 8'hFF, 5'h00, 8'h00, 4'd0, 2'd0);
        drive(1'b0, 1'b1, 8'hA6, 5'h06, 8'hA6, 4'd6, 2'd2);
        drive(1'b1, 1'b1, 8'hA4, 5'h06, 8'hA5, 4'd3, 2'd1);   // reset wins over valid
        drive(1'b0, 1'b1, 8'hA5, 5'h06, 8'hA5, 4'd0, 2'd0);

        for (int t = 0; t < 48; t++) begin
            n = t % 4;
            mask = '0;
            while ($countones(mask) < n) mask = mask | (13'd1 << $urandom_range(0, 12));
            send_err(8'($urandom_range(0, 255)), mask);
        end

        drive(1'b0, 1'b0, 8'h00, 5'h00, 8'h00, 4'd0, 2'd0);
        @(posedge clk_i);
        #3;
        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks_n, fail_n);
        $finish;
    end
endmodule
